// File: rtl/crypto_wallet2_nios_onchip_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port on-chip memory.
// Each cycle at most one Avalon-MM request is forwarded to the memory. Reads
// complete with a fixed one-cycle latency. Under contention the requester that
// was not granted most recently wins.
// Optional feature: define ONCHIP_ARB_BOUNDS_CHECK_EN to trap accesses at or
// beyond NUM_WORDS. Such accesses are still accepted, but the memory is not
// selected. An out-of-range read returns 32'hDEADBEEF and an out-of-range write
// is dropped. The first offending address is latched in err_addr alongside a
// sticky err_flag.
module crypto_wallet2_nios_onchip_mem_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 6500
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,

    output logic                err_flag,
    output logic [ADDR_W-1:0]   err_addr,
    output logic                grant_last
);

    localparam int                BE_W     = DATA_W / 8;
    localparam logic [DATA_W-1:0] OOB_DATA = DATA_W'(32'hDEADBEEF);

    // Registered state
    logic              grant_last_q, grant_last_d;
    logic              rd_vld_q,     rd_vld_d;
    logic              rd_idx_q,     rd_idx_d;
    logic              rd_oob_q,     rd_oob_d;

    // Grant decision and the selected request
    logic              req0, req1;
    logic              gnt_vld, gnt_idx;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oob;

    // Response path
    logic              rsp_vld;
    logic [DATA_W-1:0] rsp_data;

    // Arbitration: a lone requester wins at once; under contention the port
    // that did not win last time is granted. Nothing is granted during reset.
    always_comb begin
        req0    = m0_read | m0_write;
        req1    = m1_read | m1_write;
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt_vld = 1'b1;
                gnt_idx = ~grant_last_q;
            end else if (req0) begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b0;
            end else if (req1) begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b1;
            end
        end
    end

    // Request mux: a port raising both read and write is handled as a write
    always_comb begin
        if (gnt_idx) begin
            sel_write = m1_write;
            sel_addr  = m1_address;
            sel_be    = m1_byteenable;
            sel_wdata = m1_writedata;
        end else begin
            sel_write = m0_write;
            sel_addr  = m0_address;
            sel_be    = m0_byteenable;
            sel_wdata = m0_writedata;
        end
    end

`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    // Compare one bit wider than the address so that NUM_WORDS == 2**ADDR_W still works
    localparam logic [ADDR_W:0] NUM_WORDS_W = (ADDR_W+1)'(NUM_WORDS);

    logic              err_flag_q, err_flag_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    assign sel_oob = gnt_vld && ({1'b0, sel_addr} >= NUM_WORDS_W);

    // Sticky error capture: only the first out-of-range address is kept
    always_comb begin
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (sel_oob && !err_flag_q) begin
            err_flag_d = 1'b1;
            err_addr_d = sel_addr;
        end
    end

    // Error registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;
`else
    assign sel_oob  = 1'b0;
    assign err_flag = 1'b0;
    assign err_addr = '0;
`endif

    // Memory side is driven straight from the winner in the acceptance cycle
    always_comb begin
        mem_chipselect = gnt_vld & ~sel_oob;
        mem_write      = gnt_vld & ~sel_oob & sel_write;
        mem_address    = gnt_vld ? sel_addr  : '0;
        mem_byteenable = gnt_vld ? sel_be    : '0;
        mem_writedata  = gnt_vld ? sel_wdata : '0;
        mem_clken      = ~reset;
        m0_waitrequest = ~(gnt_vld & ~gnt_idx);
        m1_waitrequest = ~(gnt_vld &  gnt_idx);
    end

    // Next state: remember the winner and which port (if any) awaits read data
    always_comb begin
        grant_last_d = gnt_vld ? gnt_idx : grant_last_q;
        rd_vld_d     = gnt_vld & ~sel_write;
        rd_idx_d     = gnt_idx;
        rd_oob_d     = sel_oob;
    end

    // Arbiter and read-tracking registers
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_last_q <= 1'b1;
            rd_vld_q     <= 1'b0;
            rd_idx_q     <= 1'b0;
            rd_oob_q     <= 1'b0;
        end else begin
            grant_last_q <= grant_last_d;
            rd_vld_q     <= rd_vld_d;
            rd_idx_q     <= rd_idx_d;
            rd_oob_q     <= rd_oob_d;
        end
    end

    assign grant_last = grant_last_q;

    // Read return one cycle after acceptance. A reset landing in the return
    // cycle swallows the response. Idle ports read back zero.
    always_comb begin
        rsp_vld          = rd_vld_q & ~reset;
        rsp_data         = rd_oob_q ? OOB_DATA : mem_readdata;
        m0_readdatavalid = rsp_vld & ~rd_idx_q;
        m1_readdatavalid = rsp_vld &  rd_idx_q;
        m0_readdata      = m0_readdatavalid ? rsp_data : '0;
        m1_readdata      = m1_readdatavalid ? rsp_data : '0;
    end

endmodule

// File: tb/tb_crypto_wallet2_nios_onchip_mem_arbiter.sv
// Randomized bench for the on-chip memory arbiter. A word-level reference
// model (shadow memory and per-port pending read) predicts every output on the
// falling edge. A simple RAM model stands in for the memory behind the arbiter.
module tb_crypto_wallet2_nios_onchip_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int NW = 6500;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [AW-1:0] m0_address, m1_address;
    logic [3:0]    m0_byteenable, m1_byteenable;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic [DW-1:0] mem_writedata, mem_readdata;
    logic          err_flag, grant_last;
    logic [AW-1:0] err_addr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    crypto_wallet2_nios_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .err_flag(err_flag), .err_addr(err_addr), .grant_last(grant_last)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Memory behind the arbiter: 1-cycle read latency, byte-masked writes,
    // garbage on the read bus whenever no read was issued.
    logic [31:0] ram [0:8191];
    always @(posedge clk) begin
        if (mem_chipselect && mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        if (mem_chipselect && !mem_write) mem_readdata <= ram[mem_address];
        else                              mem_readdata <= $urandom;
    end

    // Reference model state
    logic [31:0]   shadow [0:8191];
    int            m_last  = 1;
    bit            p_v     = 0;
    int            p_idx   = 0;
    logic [31:0]   p_d     = '0;
    bit            m_err   = 0;
    logic [AW-1:0] m_eaddr = '0;
    bit            acc_now [2];

    // Predict this cycle's outputs from the inputs and model state, then advance
    always @(negedge clk) begin
        bit            rq [2];
        bit            wr [2];
        logic [AW-1:0] ad [2];
        logic [3:0]    be [2];
        logic [31:0]   wd [2];
        bit            g_v, oob;
        int            g;
        rq[0] = m0_read | m0_write; wr[0] = m0_write; ad[0] = m0_address;
        be[0] = m0_byteenable;      wd[0] = m0_writedata;
        rq[1] = m1_read | m1_write; wr[1] = m1_write; ad[1] = m1_address;
        be[1] = m1_byteenable;      wd[1] = m1_writedata;

        g_v = 0; g = 0;
        if (!reset) begin
            if (rq[0] && rq[1]) begin g_v = 1; g = 1 - m_last; end
            else if (rq[0])     begin g_v = 1; g = 0; end
            else if (rq[1])     begin g_v = 1; g = 1; end
        end
        oob = 0;
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
        oob = g_v && (int'(ad[g]) >= NW);
`endif

        chk("wait0", m0_waitrequest, !(g_v && g == 0));
        chk("wait1", m1_waitrequest, !(g_v && g == 1));
        chk("chipsel", mem_chipselect, g_v && !oob);
        chk("memwr", mem_write, g_v && !oob && wr[g]);
        chk("clken", mem_clken, !reset);
        if (g_v) begin
            chk("memaddr", mem_address, ad[g]);
            chk("membe", mem_byteenable, be[g]);
            chk("memwd", mem_writedata, wd[g]);
        end
        chk("rdv0", m0_readdatavalid, !reset && p_v && p_idx == 0);
        chk("rdv1", m1_readdatavalid, !reset && p_v && p_idx == 1);
        chk("rdd0", m0_readdata, (!reset && p_v && p_idx == 0) ? p_d : 32'h0);
        chk("rdd1", m1_readdata, (!reset && p_v && p_idx == 1) ? p_d : 32'h0);
        chk("glast", grant_last, m_last[0]);
        chk("errflag", err_flag, m_err);
        chk("erraddr", err_addr, m_eaddr);

        acc_now[0] = g_v && g == 0;
        acc_now[1] = g_v && g == 1;
        if (reset) begin
            m_last = 1; p_v = 0; m_err = 0; m_eaddr = '0;
        end else begin
            p_v   = g_v && !wr[g];
            p_idx = g;
            if (g_v) begin
                m_last = g;
                if (!wr[g]) p_d = oob ? 32'hDEADBEEF : shadow[ad[g]];
                else if (!oob)
                    for (int b = 0; b < 4; b++)
                        if (be[g][b]) shadow[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
                if (oob && !m_err) begin m_err = 1; m_eaddr = ad[g]; end
            end
        end
    end

    task automatic drv(input int n, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [3:0] b, input logic [31:0] d);
        if (n == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = b; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = b; m1_writedata = d;
        end
    endtask

    // One access from one port, held until the model sees it accepted
    task automatic acc(input int n, input bit wr, input logic [AW-1:0] a,
                       input logic [3:0] b, input logic [31:0] d);
        bit got = 0;
        drv(n, !wr, wr, a, b, d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            if (acc_now[n]) begin got = 1; break; end
        end
        chk("accept_timeout", got, 1'b1);
        @(posedge clk); #1;
        drv(n, 0, 0, '0, '0, '0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin ram[i] = '0; shadow[i] = '0; end
        reset = 1;
        drv(0, 0, 0, '0, '0, '0);
        drv(1, 0, 0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Write then read back on m0
        acc(0, 1, 13'd5, 4'hF, 32'h12345678);
        acc(0, 0, 13'd5, 4'hF, 32'h0);
        @(posedge clk); #1;

        // Partial-byte write on m1 over zero data
        acc(1, 1, 13'd7, 4'b0011, 32'hFFFFFFFF);
        acc(1, 0, 13'd7, 4'hF, 32'h0);
        @(posedge clk); #1;

        // Continuous contention right after reset: strict alternation
        pulse_reset();
        drv(0, 1, 0, 13'd5, 4'hF, 32'h0);
        drv(1, 1, 0, 13'd7, 4'hF, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        drv(0, 0, 0, '0, '0, '0);
        drv(1, 0, 0, '0, '0, '0);
        @(posedge clk); #1;

        // Reset in the response cycle kills the read
        drv(0, 1, 0, 13'd5, 4'hF, 32'h0);
        @(negedge clk); #2;
        chk("pre_reset_accept", acc_now[0], 1'b1);
        @(posedge clk); #1;
        reset = 1;
        drv(0, 0, 0, '0, '0, '0);
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1;

        // Address beyond the implemented words
        acc(0, 0, 13'd6600, 4'hF, 32'h0);
        @(posedge clk); #1;
        acc(1, 1, 13'd7000, 4'hF, 32'hA5A5A5A5);
        @(posedge clk); #1;

        // Random traffic honouring the hold-while-waitrequest rule
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                bit busy = (n == 0) ? (m0_read | m0_write) : (m1_read | m1_write);
                if (!busy || acc_now[n]) begin
                    if ($urandom_range(0, 9) < 6) begin
                        logic [AW-1:0] a;
                        int kind = $urandom_range(0, 2);
                        a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(6490, 8191))
                                                        : AW'($urandom_range(0, 15));
                        drv(n, kind != 1, kind != 0, a, 4'($urandom), $urandom);
                    end else begin
                        drv(n, 0, 0, '0, '0, '0);
                    end
                end
            end
            reset = (!reset && $urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        reset = 0;
        drv(0, 0, 0, '0, '0, '0);
        drv(1, 0, 0, '0, '0, '0);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/crypto_wallet2_nios_onchip_mem_arbiter.md
CRYPTO_WALLET2_NIOS_ONCHIP_MEM_ARBITER -- requirements
Module: crypto_wallet2_nios_onchip_mem_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 13: word-address width of the memory and both requester ports.
REQ-002 SHALL provide parameter DATA_W, default 32: data width; byteenable width is DATA_W/8.
REQ-003 SHALL provide parameter NUM_WORDS, default 6500: number of implemented memory words.
REQ-004 SHALL provide port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL provide, for each requester n in {0,1}, the inputs m<n>_read (1), m<n>_write (1), m<n>_address (ADDR_W), m<n>_byteenable (DATA_W/8) and m<n>_writedata (DATA_W).
REQ-007 SHALL provide, for each requester n, the outputs m<n>_waitrequest (1), m<n>_readdata (DATA_W) and m<n>_readdatavalid (1).
REQ-008 SHALL provide the memory-side outputs mem_chipselect (1), mem_write (1), mem_address (ADDR_W), mem_byteenable (DATA_W/8), mem_writedata (DATA_W) and mem_clken (1), plus the input mem_readdata (DATA_W).
REQ-009 SHALL provide the status outputs err_flag (1), err_addr (ADDR_W) and grant_last (1), where grant_last is the index of the most recently granted requester.

Function
REQ-010 SHALL treat requester n as requesting when m<n>_read|m<n>_write is 1; a requester asserting both is treated as a write.
REQ-011 SHALL accept at most one request per cycle; the accepted requester sees m<n>_waitrequest=0 in that cycle, and every non-accepted requester sees m<n>_waitrequest=1.
REQ-012 SHALL, when both requesters request, grant the one not equal to grant_last (round-robin); a single requester is granted immediately regardless of grant_last.
REQ-013 SHALL drive the mem_* outputs combinationally from the granted requester in the acceptance cycle, with mem_chipselect=1 and mem_write reflecting the request type; with no grant, mem_chipselect=0 and mem_write=0.
REQ-014 SHALL hold mem_clken at 1 whenever reset=0.
REQ-015 SHALL return read data with fixed latency 1: m<n>_readdatavalid=1 and m<n>_readdata=mem_readdata exactly one cycle after the read is accepted; otherwise readdatavalid=0 and readdata=0.
REQ-016 SHALL sustain back-to-back accesses, up to one per cycle, alternating between requesters under contention, with no idle bubble.
REQ-017 SHALL produce no readdatavalid for writes.
REQ-018 SHALL update grant_last only in the acceptance cycle, registered, so the new value is visible the next cycle.
REQ-019 SHALL rely on requesters holding request signals stable while waitrequest=1 (Avalon rule); the arbiter does not latch unaccepted requests.

Reset
REQ-020 SHALL, while reset=1, drive m<n>_waitrequest=1, mem_chipselect=0, mem_write=0 and mem_clken=0.
REQ-021 SHALL, at reset, clear grant_last=1 (so requester 0 wins the first contention), err_flag=0, err_addr=0, all readdatavalid=0 and all readdata=0.
REQ-022 SHALL, when reset is asserted the cycle after a read is accepted, suppress that read's readdatavalid; no response is delivered.

Configuration
REQ-023 SHALL, when macro ONCHIP_ARB_BOUNDS_CHECK_EN is defined, still accept (waitrequest=0) a request with address>=NUM_WORDS, but keep mem_chipselect=0 for it.
REQ-024 SHALL, for such an out-of-range read with ONCHIP_ARB_BOUNDS_CHECK_EN defined, return readdata=32'hDEADBEEF with readdatavalid one cycle later.
REQ-025 SHALL, for such an out-of-range write with ONCHIP_ARB_BOUNDS_CHECK_EN defined, drop the write.
REQ-026 SHALL, with ONCHIP_ARB_BOUNDS_CHECK_EN defined, set the sticky err_flag=1 and capture err_addr for the first out-of-range access; err_flag clears only on reset.
REQ-027 SHALL, when ONCHIP_ARB_BOUNDS_CHECK_EN is not defined, forward all addresses unchanged and tie err_flag=0 and err_addr=0.

Verification
REQ-028 SHALL pass this scenario: m0 writes 32'h12345678 to address 5 with byteenable 4'hF, then reads address 5 -> m0_readdatavalid asserts one cycle after the read is accepted, with m0_readdata=32'h12345678.
REQ-029 SHALL pass this scenario: both requesters read continuously after reset -> grants alternate 0,1,0,1, each waitrequest is 1 on alternate cycles, and mem_chipselect stays 1 every cycle.
REQ-030 SHALL pass this scenario: m1 writes 32'hFFFFFFFF to address 7 with byteenable 4'b0011 over initial data 0, then a read of address 7 -> 32'h0000FFFF.
REQ-031 SHALL pass this scenario: reset pulsed the cycle after m0's read is accepted -> no m0_readdatavalid, waitrequest=1 during reset, and grant_last=1 afterwards.
REQ-032 SHALL pass this scenario, with ONCHIP_ARB_BOUNDS_CHECK_EN defined: m0 reads address 6600 -> mem_chipselect=0, m0_readdata=32'hDEADBEEF one cycle later, err_flag=1 and err_addr=6600.
REQ-033 SHALL pass this scenario, with ONCHIP_ARB_BOUNDS_CHECK_EN undefined: m0 reads address 6600 -> mem_chipselect=1, mem_address=6600, and err_flag stays 0.
